pipeline_stage_register: RTL and testbench

- Generic, parametrised inter-stage register for the RV32IM pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Successor to the fixed-field stage registers. It adds:
  - a valid/ready elastic handshake with a 2-entry skid buffer;
  - synchronous flush, which turns in-flight beats into bubbles with zeroed control;
  - global BUSYWAIT stall;
  - an occupancy output.
- Data and control buses are opaque vectors; the instantiating stage packs its fields into them.

---
 rtl/pipeline_stage_register_if.sv | 12 +
 rtl/pipeline_stage_register.sv | 81 ++++++++
 tb/tb_pipeline_stage_register.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_register_if.sv
// pipeline_stage_register_if: valid/ready beat channel carrying opaque data and control payloads.
interface pipeline_stage_register_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    modport master (output valid, data, ctrl, input ready);
    modport slave  (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: elastic inter-stage register with 2-entry skid buffer, flush, global stall and occupancy.
module pipeline_stage_register #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_busywait,
    input  logic                        i_flush,
    pipeline_stage_register_if.slave    i_up,
    pipeline_stage_register_if.master   o_dn,
    output logic [1:0]                  o_occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_main_data, r_skid_data;
    logic [CTRL_WIDTH-1:0] r_main_ctrl, r_skid_ctrl;
    logic                  w_main_valid, w_skid_valid, w_acc, w_rel;
    logic                  w_load_main_in, w_load_main_skid, w_load_skid;

    assign w_main_valid = r_state != EMPTY;
    assign w_skid_valid = r_state == FULL;
    assign i_up.ready   = !w_skid_valid && !i_busywait && !i_flush;
    assign o_dn.valid   = w_main_valid && !i_busywait;
    assign o_dn.data    = r_main_data;
    assign o_dn.ctrl    = w_main_valid ? r_main_ctrl : '0;
    assign o_occupancy  = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
    assign w_acc        = i_up.valid && i_up.ready;
    assign w_rel        = o_dn.valid && o_dn.ready;

    // A release during flush is discarded along with everything else held.
    always_comb begin
        w_next           = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    w_next         = w_acc ? ONE : EMPTY;
                    w_load_main_in = w_acc;
                end
                ONE: begin
                    w_next         = (w_acc && !w_rel) ? FULL : (!w_acc && w_rel) ? EMPTY : ONE;
                    w_load_main_in = w_acc && w_rel;
                    w_load_skid    = w_acc && !w_rel;
                end
                default: begin
                    w_next           = w_rel ? ONE : FULL;
                    w_load_main_skid = w_rel;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_main_in) begin
                r_main_data <= i_up.data;
                r_main_ctrl <= i_up.ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= i_up.data;
                r_skid_ctrl <= i_up.ctrl;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb_pipeline_stage_register: queue-model scoreboard bench with directed scenarios and randomized traffic.
module tb_pipeline_stage_register;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busywait = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occupancy;
    logic       chk_en = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [39:0] exp_q[$];

    pipeline_stage_register_if #(.DATA_WIDTH(32), .CTRL_WIDTH(8)) up ();
    pipeline_stage_register_if #(.DATA_WIDTH(32), .CTRL_WIDTH(8)) dn ();

    pipeline_stage_register #(.DATA_WIDTH(32), .CTRL_WIDTH(8)) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_busywait(busywait),
        .i_flush(flush),
        .i_up(up.slave),
        .o_dn(dn.master),
        .o_occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the queue holds exactly the beats accepted and not yet released.
    always @(posedge clk) begin
        if (!rst_n || flush) exp_q.delete();
        else if (up.valid && up.ready) exp_q.push_back({up.data, up.ctrl});
    end

    // Monitor: every downstream transfer must match the oldest held beat.
    always @(posedge clk) begin
        if (chk_en && rst_n && !flush && dn.valid && dn.ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_beat: got %0h expected none at %0t", {dn.data, dn.ctrl}, $time);
            end else begin
                check("out_beat", {dn.data, dn.ctrl}, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("occupancy", 40'(occupancy), 40'(exp_q.size()));
            check("in_ready", 40'(up.ready), 40'(exp_q.size() < 2 && !busywait && !flush));
            check("out_valid", 40'(dn.valid), 40'(exp_q.size() > 0 && !busywait));
            if (exp_q.size() > 0) check("out_head", {dn.data, dn.ctrl}, exp_q[0]);
            else check("out_ctrl_idle", 40'(dn.ctrl), 40'h0);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic [7:0] c,
                       input logic ordy, input logic bw, input logic fl, input logic rn);
        up.valid = v;
        up.data  = d;
        up.ctrl  = c;
        dn.ready = ordy;
        busywait = bw;
        flush    = fl;
        rst_n    = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        up.valid = 1'b0;
        up.data  = '0;
        up.ctrl  = '0;
        dn.ready = 1'b0;
        cyc(1, 32'hDEADBEEF, 8'hFF, 1, 0, 0, 0);
        chk_en = 1'b1;
        cyc(1, 32'hDEADBEEF, 8'hFF, 1, 0, 0, 0);
        check("rst_data", 40'(dn.data), 40'h0);
        check("rst_ctrl", 40'(dn.ctrl), 40'h0);
        check("rst_occ", 40'(occupancy), 40'h0);
        check("rst_ready", 40'(up.ready), 40'h1);
        // streaming
        for (int i = 1; i <= 4; i++) cyc(1, i, 8'h81, 1, 0, 0, 1);
        check("stream_last", {dn.data, dn.ctrl}, {32'd4, 8'h81});
        cyc(0, 0, 0, 1, 0, 0, 1);
        // backpressure then drain in order
        cyc(1, 32'h10, 8'h01, 0, 0, 0, 1);
        cyc(1, 32'h20, 8'h02, 0, 0, 0, 1);
        check("bp_occ", 40'(occupancy), 40'h2);
        cyc(1, 32'h30, 8'h03, 0, 0, 0, 1);
        cyc(1, 32'h30, 8'h03, 1, 0, 0, 1);
        cyc(1, 32'h30, 8'h03, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        // flush while full with a beat offered
        cyc(1, 32'hA, 8'h0A, 0, 0, 0, 1);
        cyc(1, 32'hB, 8'h0B, 0, 0, 0, 1);
        cyc(1, 32'h40, 8'h04, 1, 0, 1, 1);
        check("flush_occ", 40'(occupancy), 40'h0);
        check("flush_ctrl", 40'(dn.ctrl), 40'h0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        // busywait holding 0x55 with a pending beat
        cyc(1, 32'h55, 8'h55, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h66, 8'h66, 1, 1, 0, 1);
            check("bw_data", 40'(dn.data), 40'h55);
        end
        cyc(1, 32'h66, 8'h66, 1, 0, 0, 1);
        check("bw_next", 40'(dn.data), 40'h66);
        cyc(0, 0, 0, 1, 0, 0, 1);
        // flush beats busywait; reset beats flush
        cyc(1, 32'h71, 8'h71, 0, 0, 0, 1);
        cyc(1, 32'h72, 8'h72, 0, 0, 0, 1);
        cyc(1, 32'h73, 8'h73, 1, 1, 1, 1);
        check("fl_bw_occ", 40'(occupancy), 40'h0);
        cyc(1, 32'h74, 8'h74, 0, 0, 0, 1);
        cyc(1, 32'h75, 8'h75, 0, 1, 1, 0);
        check("rst_fl_data", 40'(dn.data), 40'h0);
        check("rst_fl_occ", 40'(occupancy), 40'h0);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 7, $urandom, 8'($urandom), $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0);
        cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        check("drained", 40'(occupancy), 40'h0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
